// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// logic_unit_arbiter : round-robin front end sharing one bitwise logic unit
//                      between two valid/ready requesters, registered result.
// Revision: 1.0
// ============================================================================
module logic_unit_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] c_OP_AND  = 3'd0;
  localparam logic [2:0] c_OP_NAND = 3'd1;
  localparam logic [2:0] c_OP_OR   = 3'd2;
  localparam logic [2:0] c_OP_NOR  = 3'd3;
  localparam logic [2:0] c_OP_XOR  = 3'd4;
  localparam logic [2:0] c_OP_XNOR = 3'd5;
  localparam logic [2:0] c_OP_NOT  = 3'd6;

  state_t           r_state;
  logic             r_last_grant;
  logic             r_id;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_zero;
  logic             r_rsp_err;
  logic [CNT_W-1:0] r_op_count;

  logic             w_idle;
  logic             w_grant;
  logic             w_accept;
  logic [WIDTH-1:0] w_result;
  logic             w_err;

  // Contention goes to whoever did not win last; a lone requester always wins.
  assign w_idle   = (r_state == IDLE);
  assign w_grant  = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;

  // Gated by rst_n so the ready outputs read 0 while reset is held.
  assign req0_ready = rst_n && w_idle && !w_grant && req0_valid;
  assign req1_ready = rst_n && w_idle &&  w_grant && req1_valid;
  assign w_accept   = req0_ready || req1_ready;

  always_comb begin
    w_result = '0;
    w_err    = 1'b0;
    case (r_op)
      c_OP_AND:  w_result = r_a & r_b;
      c_OP_NAND: w_result = ~(r_a & r_b);
      c_OP_OR:   w_result = r_a | r_b;
      c_OP_NOR:  w_result = ~(r_a | r_b);
      c_OP_XOR:  w_result = r_a ^ r_b;
      c_OP_XNOR: w_result = ~(r_a ^ r_b);
      c_OP_NOT:  w_result = ~r_a;
      default:   w_err    = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_op_count   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op         <= w_grant ? req1_op : req0_op;
            r_a          <= w_grant ? req1_a  : req0_a;
            r_b          <= w_grant ? req1_b  : req0_b;
            r_id         <= w_grant;
            r_last_grant <= w_grant;
            r_state      <= EXEC;
          end
        end
        EXEC: begin
          r_rsp_data  <= w_result;
          r_rsp_zero  <= (w_result == '0);
          r_rsp_err   <= w_err;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_op_count  <= r_op_count + 1'b1;
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_zero  = r_rsp_zero;
  assign rsp_err   = r_rsp_err;
  assign busy      = !w_idle;
  assign op_count  = r_op_count;

endmodule
`default_nettype wire
